// File: rtl/mips_io_pkg.sv
// Shared definitions for the MIPS memory-mapped IO window at 0x7FF0-0x7FFF.
// Register offsets are word indices taken from IOAddr[3:2].
package mips_io_pkg;

  localparam logic [27:0] IO_BASE = 28'h00007ff;

  typedef enum logic [1:0] {
    IO_LED   = 2'd0,
    IO_SW    = 2'd1,
    IO_DISP  = 2'd2,
    IO_TIMER = 2'd3
  } io_reg_e;

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to active-low seven-segment glyph, segment order {g,f,e,d,c,b,a}.
module hex_to_seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: seg gets a value before the case so no path can leave it unassigned (no latch).
    seg = 7'h7f;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'ha: seg = 7'h08;
      4'hb: seg = 7'h03;
      4'hc: seg = 7'h46;
      4'hd: seg = 7'h21;
      4'he: seg = 7'h06;
      4'hf: seg = 7'h0e;
      default: seg = 7'h7f;
    endcase
  end

endmodule

// File: rtl/mips_io_ctrl.sv
// IO responder for the MIPS core: LED, synchronized switches, multiplexed
// 4-digit display and a one-shot down-timer, with a combinational read mux.
module mips_io_ctrl
  import mips_io_pkg::*;
#(
  parameter int SCAN_DIV = 18
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOWriteData,
  input  logic [3:0]  IOAddr,
  input  logic        IOWriteEn,
  output logic [31:0] IOReadData,
  input  logic [7:0]  Switches,
  output logic [7:0]  LED,
  output logic [3:0]  AN,
  output logic [6:0]  SegOut
);

  logic [7:0]          led_val;
  logic [7:0]          sw_meta;
  logic [7:0]          sw_sync;
  logic [15:0]         disp_val;
  logic [30:0]         count;
  logic                expired;
  logic [SCAN_DIV-1:0] scan_cnt;
  logic [3:0]          an_val;
  logic [6:0]          seg_val;

  logic       wr_led;
  logic       wr_disp;
  logic       wr_timer;
  logic [1:0] digit;
  logic [3:0] nibble;
  logic [6:0] glyph;
  logic [3:0] an_next;

  // Byte lanes and the top timer bit are architecturally ignored.
  logic unused_bits;
  assign unused_bits = &{1'b0, IOAddr[1:0], IOWriteData[31]};

  assign wr_led   = IOWriteEn && (IOAddr[3:2] == IO_LED);
  assign wr_disp  = IOWriteEn && (IOAddr[3:2] == IO_DISP);
  assign wr_timer = IOWriteEn && (IOAddr[3:2] == IO_TIMER);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      led_val  <= '0;
      disp_val <= '0;
    end else begin
      if (wr_led)  led_val  <= IOWriteData[7:0];
      if (wr_disp) disp_val <= IOWriteData[15:0];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= Switches;
      sw_sync <= sw_meta;
    end
  end

  // A write always beats the decrement; expiry fires only on a 1 -> 0 step.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (wr_timer) begin
      count   <= IOWriteData[30:0];
      expired <= 1'b0;
    end else if (count != '0) begin
      count <= count - 31'd1;
      if (count == 31'd1) expired <= 1'b1;
    end
  end

  assign digit   = scan_cnt[SCAN_DIV-1 -: 2];
  assign nibble  = disp_val[{digit, 2'b00} +: 4];
  assign an_next = ~(4'b0001 << digit);

  hex_to_seg u_hex_to_seg (
    .hex (nibble),
    .seg (glyph)
  );

  // Anode and segment drive are registered so the pins switch glitch-free.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      scan_cnt <= '0;
      an_val   <= 4'b1110;
      seg_val  <= 7'h40;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      an_val   <= an_next;
      seg_val  <= glyph;
    end
  end

  assign LED    = led_val;
  assign AN     = an_val;
  assign SegOut = seg_val;

  always_comb begin
    IOReadData = '0;
    case (io_reg_e'(IOAddr[3:2]))
      IO_LED:   IOReadData = {24'b0, led_val};
      IO_SW:    IOReadData = {24'b0, sw_sync};
      IO_DISP:  IOReadData = {16'b0, disp_val};
      IO_TIMER: IOReadData = {expired, count};
      default:  IOReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_mips_io_ctrl.sv
// Directed bench for mips_io_ctrl with SCAN_DIV=4: display scan, LED, switches,
// timer countdown/expiry/collision and asynchronous reset.
module tb_mips_io_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] IOWriteData;
  logic [3:0]  IOAddr;
  logic        IOWriteEn;
  logic [31:0] IOReadData;
  logic [7:0]  Switches;
  logic [7:0]  LED;
  logic [3:0]  AN;
  logic [6:0]  SegOut;

  int total = 0;
  int fails = 0;

  mips_io_ctrl #(.SCAN_DIV(4)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IOWriteData (IOWriteData),
    .IOAddr      (IOAddr),
    .IOWriteEn   (IOWriteEn),
    .IOReadData  (IOReadData),
    .Switches    (Switches),
    .LED         (LED),
    .AN          (AN),
    .SegOut      (SegOut)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic io_write(input logic [3:0] addr, input logic [31:0] data);
    IOAddr      = addr;
    IOWriteData = data;
    IOWriteEn   = 1'b1;
    tick();
    IOWriteEn   = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    IOAddr = addr;
    #1;
    check(tag, IOReadData, exp);
  endtask

  logic [6:0] glyph_exp [4];
  logic [3:0] an_exp;

  initial begin
    glyph_exp = '{7'h0E, 7'h08, 7'h24, 7'h79};
    RESET = 1'b1;
    IOWriteData = '0;
    IOAddr = '0;
    IOWriteEn = 1'b0;
    Switches = 8'h00;
    #12;
    check("rst_led", {24'b0, LED}, 32'h0);
    check("rst_an", {28'b0, AN}, 32'he);
    check("rst_seg", {25'b0, SegOut}, 32'h40);

    // Display: release reset, write DISP on edge 1, then observe one full scan period.
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    io_write(4'h8, 32'h0000_12AF);
    rd_check("disp_read", 4'h8, 32'h0000_12AF);
    repeat (15) tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      an_exp = 4'b0001 << (i / 4);
      an_exp = ~an_exp;
      check($sformatf("disp_an_%0d", i), {28'b0, AN}, {28'b0, an_exp});
      check($sformatf("disp_seg_%0d", i), {25'b0, SegOut}, {25'b0, glyph_exp[i/4]});
    end

    // Switches: two-flop synchronizer latency.
    Switches = 8'h3C;
    rd_check("sw_edge0", 4'h4, 32'h0);
    tick();
    rd_check("sw_edge1", 4'h4, 32'h0);
    tick();
    rd_check("sw_edge2", 4'h4, 32'h3C);

    // LED write, readback, and a write to the read-only SW offset.
    io_write(4'h0, 32'h0000_01A5);
    check("led_pins", {24'b0, LED}, 32'hA5);
    rd_check("led_read", 4'h0, 32'h0000_00A5);
    io_write(4'h4, 32'h0000_0055);
    check("led_after_sw_wr", {24'b0, LED}, 32'hA5);
    rd_check("sw_after_wr", 4'h4, 32'h3C);
    rd_check("led_read2", 4'h0, 32'h0000_00A5);

    // Timer countdown and sticky expiry.
    io_write(4'hC, 32'd5);
    rd_check("tmr_5", 4'hC, 32'd5);
    for (int k = 4; k >= 1; k--) begin
      tick();
      rd_check($sformatf("tmr_%0d", k), 4'hC, k);
    end
    tick();
    rd_check("tmr_expired", 4'hC, 32'h8000_0000);
    tick();
    tick();
    rd_check("tmr_sticky", 4'hC, 32'h8000_0000);
    io_write(4'hC, 32'd3);
    rd_check("tmr_rewrite", 4'hC, 32'd3);
    io_write(4'hC, 32'd0);
    rd_check("tmr_zero", 4'hC, 32'h0);
    tick();
    tick();
    rd_check("tmr_zero_hold", 4'hC, 32'h0);

    // Collision: write 7 while Count=2; the write wins.
    io_write(4'hC, 32'd3);
    tick();
    rd_check("tmr_pre_coll", 4'hC, 32'd2);
    io_write(4'hC, 32'd7);
    rd_check("tmr_coll_wr", 4'hC, 32'd7);
    tick();
    rd_check("tmr_coll_next", 4'hC, 32'd6);

    // Asynchronous reset mid-operation.
    io_write(4'hC, 32'd100);
    io_write(4'h8, 32'h0000_BEEF);
    #2;
    RESET = 1'b1;
    #1;
    check("mrst_led", {24'b0, LED}, 32'h0);
    check("mrst_an", {28'b0, AN}, 32'he);
    check("mrst_seg", {25'b0, SegOut}, 32'h40);
    rd_check("mrst_rd0", 4'h0, 32'h0);
    rd_check("mrst_rd4", 4'h4, 32'h0);
    rd_check("mrst_rd8", 4'h8, 32'h0);
    rd_check("mrst_rdC", 4'hC, 32'h0);
    tick();
    RESET = 1'b0;
    tick();
    tick();
    rd_check("mrst_tmr_abort", 4'hC, 32'h0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
